// File: rtl/vga_dac_palette.sv
// VGA DAC palette: 256-entry {R,G,B} lookup loaded through the 3C6..3C9 port set,
// translating the sequencer pixel index into an rgb word through a 2-cycle pipe.
module vga_dac_palette #(
  parameter int DAC_BITS = 6,
  parameter bit PAL_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_cs,
  input  logic                  io_wr,
  input  logic [1:0]            io_addr,
  input  logic [7:0]            io_din,
  output logic [7:0]            io_dout,
  output logic                  io_dout_valid,
  input  logic [7:0]            pix_index,
  input  logic                  pix_blank,
  output logic [3*DAC_BITS-1:0] rgb
);
  localparam int RGB_W = 3 * DAC_BITS;

  typedef enum logic [1:0] {COMP_R = 2'd0, COMP_G = 2'd1, COMP_B = 2'd2} comp_e;
  typedef enum logic [1:0] {
    REG_MASK = 2'd0, REG_RD_IDX = 2'd1, REG_WR_IDX = 2'd2, REG_DATA = 2'd3
  } port_e;

  function automatic comp_e comp_next(input comp_e c);
    case (c)
      COMP_R:  return COMP_G;
      COMP_G:  return COMP_B;
      default: return COMP_R;
    endcase
  endfunction

  port_e addr;
  assign addr = port_e'(io_addr);

  // CPU-side state
  logic [7:0]          mask_q, mask_d;
  logic [7:0]          wr_idx_q, wr_idx_d;
  logic [7:0]          rd_idx_q, rd_idx_d;
  comp_e               comp_q, comp_d;
  logic [1:0]          dac_state_q, dac_state_d;
  logic [DAC_BITS-1:0] hold_r_q, hold_r_d;
  logic [DAC_BITS-1:0] hold_g_q, hold_g_d;

  // Read pipeline: stage 1 captures the request, stage 2 drives io_dout
  logic                rd_pend_q, rd_pend_d;
  logic                rd_pal_q, rd_pal_d;
  comp_e               rd_comp_q, rd_comp_d;
  logic [7:0]          rd_reg_q, rd_reg_d;
  logic [7:0]          io_dout_q, io_dout_d;
  logic                io_dout_valid_q;
  logic [DAC_BITS-1:0] cpu_comp;

  // Pixel pipeline
  logic                pix_blank_q;
  logic [RGB_W-1:0]    rgb_q, rgb_d;
  logic [7:0]          pix_addr;

  // Palette RAM ports
  logic                pal_we;
  logic [7:0]          pal_waddr;
  logic [RGB_W-1:0]    pal_wdata;
  logic [RGB_W-1:0]    cpu_word_q;
  logic [RGB_W-1:0]    pix_word_q;

  assign pix_addr = pix_index & mask_q;

  always_comb begin
    // NOTE: every variable gets a default first so no branch can leave one unassigned and infer a latch.
    mask_d      = mask_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    comp_d      = comp_q;
    dac_state_d = dac_state_q;
    hold_r_d    = hold_r_q;
    hold_g_d    = hold_g_q;
    rd_pend_d   = 1'b0;
    rd_pal_d    = 1'b0;
    rd_comp_d   = comp_q;
    rd_reg_d    = 8'h00;
    pal_we      = 1'b0;
    pal_waddr   = wr_idx_q;
    pal_wdata   = {hold_r_q, hold_g_q, io_din[DAC_BITS-1:0]};

    if (io_cs && io_wr) begin
      case (addr)
        REG_MASK: mask_d = io_din;
        REG_RD_IDX: begin
          rd_idx_d    = io_din;
          comp_d      = COMP_R;
          dac_state_d = 2'b11;
        end
        REG_WR_IDX: begin
          wr_idx_d    = io_din;
          comp_d      = COMP_R;
          dac_state_d = 2'b00;
        end
        default: begin
          case (comp_q)
            COMP_R:  hold_r_d = io_din[DAC_BITS-1:0];
            COMP_G:  hold_g_d = io_din[DAC_BITS-1:0];
            default: begin
              // Reset wins over a commit sampled in the same cycle
              pal_we   = !reset;
              wr_idx_d = wr_idx_q + 8'd1;
            end
          endcase
          comp_d = comp_next(comp_q);
        end
      endcase
    end else if (io_cs) begin
      rd_pend_d = 1'b1;
      case (addr)
        REG_MASK:   rd_reg_d = mask_q;
        REG_RD_IDX: rd_reg_d = {6'b000000, dac_state_q};
        REG_WR_IDX: rd_reg_d = wr_idx_q;
        default: begin
          rd_pal_d = 1'b1;
          comp_d   = comp_next(comp_q);
          if (comp_q == COMP_B) rd_idx_d = rd_idx_q + 8'd1;
        end
      endcase
    end
  end

  always_comb begin
    case (rd_comp_q)
      COMP_R:  cpu_comp = cpu_word_q[RGB_W-1 -: DAC_BITS];
      COMP_G:  cpu_comp = cpu_word_q[2*DAC_BITS-1 -: DAC_BITS];
      default: cpu_comp = cpu_word_q[DAC_BITS-1:0];
    endcase
    io_dout_d = io_dout_q;
    if (rd_pend_q) io_dout_d = rd_pal_q ? 8'(cpu_comp) : rd_reg_q;
    rgb_d = pix_blank_q ? '0 : pix_word_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      mask_q          <= 8'hFF;
      wr_idx_q        <= 8'h00;
      rd_idx_q        <= 8'h00;
      comp_q          <= COMP_R;
      dac_state_q     <= 2'b00;
      hold_r_q        <= '0;
      hold_g_q        <= '0;
      rd_pend_q       <= 1'b0;
      rd_pal_q        <= 1'b0;
      rd_comp_q       <= COMP_R;
      rd_reg_q        <= 8'h00;
      io_dout_q       <= 8'h00;
      io_dout_valid_q <= 1'b0;
      pix_blank_q     <= 1'b1;  // first post-reset pixel cannot leak stale RAM data
      rgb_q           <= '0;
    end else begin
      mask_q          <= mask_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      comp_q          <= comp_d;
      dac_state_q     <= dac_state_d;
      hold_r_q        <= hold_r_d;
      hold_g_q        <= hold_g_d;
      rd_pend_q       <= rd_pend_d;
      rd_pal_q        <= rd_pal_d;
      rd_comp_q       <= rd_comp_d;
      rd_reg_q        <= rd_reg_d;
      io_dout_q       <= io_dout_d;
      io_dout_valid_q <= rd_pend_q;
      pix_blank_q     <= pix_blank;
      rgb_q           <= rgb_d;
    end
  end

  // NOTE: the palette RAM has no reset so it maps onto block RAM and its contents survive reset.
  if (PAL_INIT) begin : g_ram_init
    logic [RGB_W-1:0] pal_mem [256] = '{default: '0};
    always_ff @(posedge clk) begin
      if (pal_we) pal_mem[pal_waddr] <= pal_wdata;
      cpu_word_q <= pal_mem[rd_idx_q];
      pix_word_q <= pal_mem[pix_addr];
    end
  end else begin : g_ram
    logic [RGB_W-1:0] pal_mem [256];
    always_ff @(posedge clk) begin
      if (pal_we) pal_mem[pal_waddr] <= pal_wdata;
      cpu_word_q <= pal_mem[rd_idx_q];
      pix_word_q <= pal_mem[pix_addr];
    end
  end

  assign io_dout       = io_dout_q;
  assign io_dout_valid = io_dout_valid_q;
  assign rgb           = rgb_q;

endmodule

// File: tb/tb_vga_dac_palette.sv
// Bench for vga_dac_palette: directed scenarios with fixed expected values plus a
// randomized run checked cycle by cycle against a behavioural DAC model.
module tb_vga_dac_palette;
  localparam int DB = 6;
  localparam int RW = 3 * DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_cs;
  logic          io_wr;
  logic [1:0]    io_addr;
  logic [7:0]    io_din;
  logic [7:0]    io_dout;
  logic          io_dout_valid;
  logic [7:0]    pix_index;
  logic          pix_blank;
  logic [RW-1:0] rgb;

  int errors = 0;
  int checks = 0;

  vga_dac_palette #(.DAC_BITS(DB), .PAL_INIT(1'b0)) dut (
    .clk(clk), .reset(reset), .io_cs(io_cs), .io_wr(io_wr), .io_addr(io_addr),
    .io_din(io_din), .io_dout(io_dout), .io_dout_valid(io_dout_valid),
    .pix_index(pix_index), .pix_blank(pix_blank), .rgb(rgb)
  );

  always #5 clk = ~clk;

  // Behavioural model: palette as an array, component counter as 0/1/2
  logic [RW-1:0] m_pal [256];
  logic [7:0]    m_mask, m_wr, m_rd;
  int            m_comp;
  logic [1:0]    m_state;
  logic [DB-1:0] m_hold_r, m_hold_g;
  logic [RW-1:0] p_rgb, exp_rgb;
  logic          p_v, exp_valid;
  logic [7:0]    p_val, exp_dout;
  logic [7:0]    cur_pix;
  logic          cur_blank;

  function automatic logic [DB-1:0] comp_of(input logic [RW-1:0] w, input int c);
    return w[RW-1-c*DB -: DB];
  endfunction

  // One clock: drive at the falling edge, model the rising edge, return at the next falling edge
  task automatic step(input logic cs, input logic wr, input logic [1:0] addr, input logic [7:0] din,
                      input logic [7:0] pix, input logic blank, input logic rst);
    logic [RW-1:0] nrgb;
    logic          nv;
    logic [7:0]    nval;
    reset = rst; io_cs = cs; io_wr = wr; io_addr = addr; io_din = din;
    pix_index = pix; pix_blank = blank;
    nrgb = blank ? '0 : m_pal[pix & m_mask];
    nv   = cs && !wr;
    nval = 8'h00;
    if (nv) begin
      case (addr)
        2'd0:    nval = m_mask;
        2'd1:    nval = {6'b000000, m_state};
        2'd2:    nval = m_wr;
        default: nval = 8'(comp_of(m_pal[m_rd], m_comp));
      endcase
    end
    @(posedge clk);
    if (rst) begin
      m_mask = 8'hFF; m_wr = 8'h00; m_rd = 8'h00; m_comp = 0; m_state = 2'b00;
      m_hold_r = '0; m_hold_g = '0;
      exp_rgb = '0; p_rgb = '0; exp_valid = 1'b0; p_v = 1'b0; exp_dout = 8'h00; p_val = 8'h00;
    end else begin
      exp_rgb = p_rgb;
      p_rgb = nrgb;
      exp_valid = p_v;
      if (p_v) exp_dout = p_val;
      p_v = nv;
      p_val = nval;
      if (cs && wr) begin
        case (addr)
          2'd0: m_mask = din;
          2'd1: begin m_rd = din; m_comp = 0; m_state = 2'b11; end
          2'd2: begin m_wr = din; m_comp = 0; m_state = 2'b00; end
          default: begin
            if (m_comp == 0) m_hold_r = din[DB-1:0];
            else if (m_comp == 1) m_hold_g = din[DB-1:0];
            else begin
              m_pal[m_wr] = {m_hold_r, m_hold_g, din[DB-1:0]};
              m_wr = m_wr + 8'd1;
            end
            m_comp = (m_comp + 1) % 3;
          end
        endcase
      end else if (cs && addr == 2'd3) begin
        if (m_comp == 2) m_rd = m_rd + 8'd1;
        m_comp = (m_comp + 1) % 3;
      end
    end
    @(negedge clk);
  endtask

  task automatic wr_io(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, cur_pix, cur_blank, 1'b0);
  endtask

  task automatic rd_io(input logic [1:0] a);
    step(1'b1, 1'b0, a, 8'h00, cur_pix, cur_blank, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 8'h00, cur_pix, cur_blank, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 2'd0, 8'h00, cur_pix, cur_blank, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    wr_io(2'd2, 8'h00);
    for (int i = 0; i < 768; i++) wr_io(2'd3, 8'h00);
    do_reset();
    do_reset();
    checks++;
    if ({rgb, io_dout_valid, io_dout} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {rgb, io_dout_valid, io_dout});
    end
    rd_io(2'd0);
    rd_io(2'd1);
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'hFF}) begin
      errors++; $display("FAIL reset_rd_3c6: got %h expected 1ff", {io_dout_valid, io_dout});
    end
    rd_io(2'd2);
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_rd_3c7: got %h expected 100", {io_dout_valid, io_dout});
    end
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_rd_3c8: got %h expected 100", {io_dout_valid, io_dout});
    end
    for (int i = 0; i < 8; i++) begin
      cur_pix = 8'($urandom);
      idle();
      checks++;
      if ({io_dout_valid, rgb} !== '0) begin
        errors++; $display("FAIL reset_sweep_%0d: got %h expected 0", i, {io_dout_valid, rgb});
      end
    end
  endtask

  task automatic test_write_pixel();
    wr_io(2'd2, 8'h05);
    wr_io(2'd3, 8'h3F);
    wr_io(2'd3, 8'h15);
    wr_io(2'd3, 8'h2A);
    cur_pix = 8'h05;
    idle();
    idle();
    checks++;
    if (rgb !== 18'b111111_010101_101010) begin
      errors++; $display("FAIL write_pixel_05: rgb=%h expected %h", rgb, 18'b111111_010101_101010);
    end
    rd_io(2'd2);
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h06}) begin
      errors++; $display("FAIL write_rd_3c8: got %h expected 106", {io_dout_valid, io_dout});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h3F, 8'h15, 8'h2A, 8'h03, 8'h0A};
    wr_io(2'd3, 8'h0A);
    wr_io(2'd3, 8'h0B);
    wr_io(2'd3, 8'h0C);
    wr_io(2'd1, 8'h05);
    rd_io(2'd3);
    for (int i = 0; i < 5; i++) begin
      if (i < 2 || i == 3) rd_io(2'd3);
      else if (i == 2) rd_io(2'd1);
      else idle();
      checks++;
      if ({io_dout_valid, io_dout} !== {1'b1, exp_seq[i]}) begin
        errors++;
        $display("FAIL b2b_read_%0d: got %h expected %h", i, {io_dout_valid, io_dout}, {1'b1, exp_seq[i]});
      end
    end
  endtask

  task automatic test_wrap();
    wr_io(2'd2, 8'hFF);
    for (int i = 1; i <= 6; i++) wr_io(2'd3, 8'(i));
    cur_pix = 8'hFF;
    idle();
    idle();
    checks++;
    if (rgb !== {6'd1, 6'd2, 6'd3}) begin
      errors++; $display("FAIL wrap_entry_ff: rgb=%h expected %h", rgb, {6'd1, 6'd2, 6'd3});
    end
    cur_pix = 8'h00;
    idle();
    idle();
    checks++;
    if (rgb !== {6'd4, 6'd5, 6'd6}) begin
      errors++; $display("FAIL wrap_entry_00: rgb=%h expected %h", rgb, {6'd4, 6'd5, 6'd6});
    end
    rd_io(2'd2);
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL wrap_wr_idx: got %h expected 101", {io_dout_valid, io_dout});
    end
    wr_io(2'd1, 8'hFF);
    rd_io(2'd3);
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) rd_io(2'd3);
      else idle();
      checks++;
      if ({io_dout_valid, io_dout} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL wrap_rd_idx_%0d: got %h expected %h", i, {io_dout_valid, io_dout}, {1'b1, 8'(i)});
      end
    end
  endtask

  task automatic test_mask_blank();
    wr_io(2'd0, 8'h0F);
    cur_pix = 8'hF5;
    idle();
    idle();
    checks++;
    if (rgb !== 18'b111111_010101_101010) begin
      errors++; $display("FAIL mask_f5: rgb=%h expected %h", rgb, 18'b111111_010101_101010);
    end
    rd_io(2'd0);
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h0F}) begin
      errors++; $display("FAIL mask_rd_3c6: got %h expected 10f", {io_dout_valid, io_dout});
    end
    cur_blank = 1'b1;
    idle();
    checks++;
    if (rgb !== 18'b111111_010101_101010) begin
      errors++; $display("FAIL blank_early: rgb=%h expected %h", rgb, 18'b111111_010101_101010);
    end
    idle();
    checks++;
    if (rgb !== '0) begin
      errors++; $display("FAIL blank_zero: rgb=%h expected 0", rgb);
    end
    cur_blank = 1'b0;
    wr_io(2'd0, 8'hFF);
  endtask

  task automatic test_reset_mid();
    wr_io(2'd2, 8'h10);
    wr_io(2'd3, 8'h11);
    wr_io(2'd3, 8'h22);
    wr_io(2'd3, 8'h33);
    wr_io(2'd2, 8'h10);
    wr_io(2'd3, 8'h3F);
    wr_io(2'd3, 8'h3F);
    cur_pix = 8'h10;
    step(1'b1, 1'b1, 2'd3, 8'h3F, cur_pix, cur_blank, 1'b1);
    idle();
    idle();
    checks++;
    if (rgb !== {6'h11, 6'h22, 6'h33}) begin
      errors++; $display("FAIL midreset_palette: rgb=%h expected %h", rgb, {6'h11, 6'h22, 6'h33});
    end
    rd_io(2'd2);
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL midreset_wr_idx: got %h expected 100", {io_dout_valid, io_dout});
    end
    wr_io(2'd2, 8'h10);
    for (int i = 0; i < 3; i++) wr_io(2'd3, 8'h00);
    idle();
    idle();
    checks++;
    if (rgb !== '0) begin
      errors++; $display("FAIL midreset_entry10: rgb=%h expected 0", rgb);
    end
    rd_io(2'd2);
    idle();
    checks++;
    if ({io_dout_valid, io_dout} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL midreset_wr_idx_11: got %h expected 111", {io_dout_valid, io_dout});
    end
    wr_io(2'd2, 8'h20);
    for (int i = 0; i < 3; i++) wr_io(2'd3, 8'h01);
    wr_io(2'd2, 8'h20);
    wr_io(2'd3, 8'h2A);
    wr_io(2'd3, 8'h15);
    cur_pix = 8'h20;
    wr_io(2'd3, 8'h3F);
    idle();
    checks++;
    if (rgb !== {6'h01, 6'h01, 6'h01}) begin
      errors++; $display("FAIL collide_old: rgb=%h expected %h", rgb, {6'h01, 6'h01, 6'h01});
    end
    idle();
    checks++;
    if (rgb !== {6'h2A, 6'h15, 6'h3F}) begin
      errors++; $display("FAIL collide_new: rgb=%h expected %h", rgb, {6'h2A, 6'h15, 6'h3F});
    end
  endtask

  task automatic test_random();
    logic       rst, cs, wr;
    logic [1:0] addr;
    logic [7:0] din;
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cs        = 1'($urandom_range(0, 1));
      wr        = 1'($urandom_range(0, 1));
      addr      = 2'($urandom);
      din       = 8'($urandom);
      if (wr && addr == 2'd0 && $urandom_range(0, 1) == 1) din = 8'hFF;
      cur_pix   = 8'($urandom);
      cur_blank = ($urandom_range(0, 7) == 0);
      step(cs, wr, addr, din, cur_pix, cur_blank, rst);
      checks++;
      if (rgb !== exp_rgb) begin
        errors++; $display("FAIL rand_rgb_%0d: rgb=%h expected %h", i, rgb, exp_rgb);
      end
      checks++;
      if (io_dout_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid_%0d: got %b expected %b", i, io_dout_valid, exp_valid);
      end
      checks++;
      if (io_dout !== exp_dout) begin
        errors++; $display("FAIL rand_dout_%0d: got %h expected %h", i, io_dout, exp_dout);
      end
    end
  endtask

  initial begin
    foreach (m_pal[i]) m_pal[i] = '0;
    m_mask = 8'hFF; m_wr = 8'h00; m_rd = 8'h00; m_comp = 0; m_state = 2'b00;
    m_hold_r = '0; m_hold_g = '0;
    p_rgb = '0; exp_rgb = '0; p_v = 1'b0; exp_valid = 1'b0; p_val = 8'h00; exp_dout = 8'h00;
    cur_pix = 8'h00; cur_blank = 1'b0;
    test_reset();
    test_write_pixel();
    test_back_to_back();
    test_wrap();
    test_mask_blank();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
